// File: rtl/div_requester_if.sv
// Handshake bundle between the divider client, its command/response users and the divider.
// The master modport is the requester's view; slave is the view of everything around it.
interface div_requester_if #(
    parameter int N = 16
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_dividend;
    logic [N-1:0] cmd_divisor;
    logic         div_req;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic [N-1:0] div_q;
    logic         div_ready;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_q;
    logic [N-1:0] rsp_r;
    logic         rsp_exc;
    logic         rsp_timeout;
    logic         div_hung;

    modport master (
        input  cmd_valid, cmd_dividend, cmd_divisor, div_q, div_ready, rsp_ready,
        output cmd_ready, div_req, div_dividend, div_divisor,
        output rsp_valid, rsp_q, rsp_r, rsp_exc, rsp_timeout, div_hung
    );

    modport slave (
        output cmd_valid, cmd_dividend, cmd_divisor, div_q, div_ready, rsp_ready,
        input  cmd_ready, div_req, div_dividend, div_divisor,
        input  rsp_valid, rsp_q, rsp_r, rsp_exc, rsp_timeout, div_hung
    );
endinterface

// File: rtl/div_requester.sv
// Divider client: buffers operand pairs, issues them one at a time to the iterative
// divider, forms the remainder locally and traps divide-by-zero and divider hangs.
module div_requester #(
    parameter int N       = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rstn,
    div_requester_if.master bus
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [TW-1:0] TIM_ONE  = TW'(1);
    localparam logic [TW-1:0] TIM_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t        state_r, state_next_s;

    logic [N-1:0]  fifo_dvd_r [DEPTH];
    logic [N-1:0]  fifo_dvs_r [DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r, count_next_s;
    logic          cmd_ready_r;
    logic          push_s, pop_s;
    logic [N-1:0]  head_dvd_s, head_dvs_s;

    logic [N-1:0]  a_r, b_r;
    logic [N-1:0]  prod_s, rem_s;
    logic [TW-1:0] timer_r;

    logic          div_req_r;
    logic [N-1:0]  div_dividend_r, div_divisor_r;
    logic          rsp_valid_r, rsp_exc_r, rsp_timeout_r, div_hung_r;
    logic [N-1:0]  rsp_q_r, rsp_r_r;

    logic          issue_s, div0_s, capture_s, timeout_s, done_s, timer_inc_s;

    assign push_s     = bus.cmd_valid && cmd_ready_r;
    assign head_dvd_s = fifo_dvd_r[rd_ptr_r];
    assign head_dvs_s = fifo_dvs_r[rd_ptr_r];

    // Remainder is reconstructed from the divider's quotient, modulo 2^N.
    assign prod_s = bus.div_q * b_r;
    assign rem_s  = a_r - prod_s;

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
    end

    // Command FIFO storage, pointers and registered ready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_dvd_r[i] <= {N{1'b0}};
                fifo_dvs_r[i] <= {N{1'b0}};
            end
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            count_r     <= {CW{1'b0}};
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_dvd_r[wr_ptr_r] <= bus.cmd_dividend;
                fifo_dvs_r[wr_ptr_r] <= bus.cmd_divisor;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r     <= count_next_s;
            cmd_ready_r <= (count_next_s != CNT_FULL);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and per-cycle strobes
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        issue_s      = 1'b0;
        div0_s       = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        done_s       = 1'b0;
        timer_inc_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != {CW{1'b0}}) && !div_hung_r) begin
                    pop_s = 1'b1;
                    if (head_dvs_s == {N{1'b0}}) begin
                        div0_s       = 1'b1;
                        state_next_s = ST_RESP;
                    end else begin
                        issue_s      = 1'b1;
                        state_next_s = ST_ISSUE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.div_ready) begin
                    capture_s    = 1'b1;
                    state_next_s = ST_DRAIN;
                end else if (timer_r == TIM_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    timer_inc_s  = 1'b1;
                    state_next_s = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                if (!bus.div_ready) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    done_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Working operands, divider-facing registers and request pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_r            <= {N{1'b0}};
            b_r            <= {N{1'b0}};
            div_dividend_r <= {N{1'b0}};
            div_divisor_r  <= {N{1'b0}};
            div_req_r      <= 1'b0;
        end else begin
            if (pop_s) begin
                a_r <= head_dvd_s;
                b_r <= head_dvs_s;
            end
            if (issue_s) begin
                div_dividend_r <= head_dvd_s;
                div_divisor_r  <= head_dvs_s;
            end
            // High exactly while the FSM sits in ISSUE.
            div_req_r <= issue_s;
        end
    end

    // Divider response watchdog
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timer_r <= {TW{1'b0}};
        end else if (state_r == ST_ISSUE) begin
            timer_r <= {TW{1'b0}};
        end else if (timer_inc_s) begin
            timer_r <= timer_r + TIM_ONE;
        end
    end

    // Response holding registers and sticky hang flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_r   <= 1'b0;
            rsp_q_r       <= {N{1'b0}};
            rsp_r_r       <= {N{1'b0}};
            rsp_exc_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            div_hung_r    <= 1'b0;
        end else begin
            if (div0_s) begin
                rsp_exc_r <= 1'b1;
                rsp_q_r   <= {N{1'b1}};
                rsp_r_r   <= head_dvd_s;
            end
            if (capture_s) begin
                rsp_q_r <= bus.div_q;
                rsp_r_r <= rem_s;
            end
            if (timeout_s) begin
                rsp_timeout_r <= 1'b1;
                rsp_q_r       <= {N{1'b0}};
                rsp_r_r       <= {N{1'b0}};
                div_hung_r    <= 1'b1;
            end
            if (done_s) begin
                rsp_valid_r   <= 1'b0;
                rsp_exc_r     <= 1'b0;
                rsp_timeout_r <= 1'b0;
            end else if (state_r == ST_RESP) begin
                rsp_valid_r <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready    = cmd_ready_r;
    assign bus.div_req      = div_req_r;
    assign bus.div_dividend = div_dividend_r;
    assign bus.div_divisor  = div_divisor_r;
    assign bus.rsp_valid    = rsp_valid_r;
    assign bus.rsp_q        = rsp_q_r;
    assign bus.rsp_r        = rsp_r_r;
    assign bus.rsp_exc      = rsp_exc_r;
    assign bus.rsp_timeout  = rsp_timeout_r;
    assign bus.div_hung     = div_hung_r;

endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester: table of divisions plus sequences for
// back-pressure, FIFO fill, hold-off, mid-operation reset and divider timeout.
module tb_div_requester;

    logic clk;
    logic rstn;

    div_requester_if #(.N(16)) bus ();

    div_requester #(.N(16), .DEPTH(4), .TIMEOUT(1024)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        exc;
    } vec_t;

    vec_t tbl  [9];
    vec_t six  [6];

    // Behavioural divider stub state
    int          cyc = 0;
    int          div_lat = 20;
    bit          div_dead = 1'b0;
    int          req_pulses = 0;
    int          req_while_ready = 0;
    int          last_req_cyc = 0;
    bit          st_busy;
    int          st_cnt;
    int          st_hold;
    logic [15:0] st_a, st_b;

    logic [33:0] rsp_fifo [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: answers L cycles after req, holds ready for two cycles
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.div_ready <= 1'b0;
            bus.div_q     <= 16'd0;
            st_busy       <= 1'b0;
            st_cnt        <= 0;
            st_hold       <= 0;
        end else begin
            if (bus.div_req) begin
                req_pulses   <= req_pulses + 1;
                last_req_cyc <= cyc;
                if (bus.div_ready) req_while_ready <= req_while_ready + 1;
                st_busy <= 1'b1;
                st_cnt  <= div_lat;
                st_a    <= bus.div_dividend;
                st_b    <= bus.div_divisor;
            end else if (st_busy) begin
                if (!div_dead) begin
                    if (st_cnt <= 1) begin
                        st_busy       <= 1'b0;
                        bus.div_ready <= 1'b1;
                        bus.div_q     <= (st_b == 16'd0) ? 16'hFFFF : st_a / st_b;
                        st_hold       <= 2;
                    end else begin
                        st_cnt <= st_cnt - 1;
                    end
                end
            end else if (bus.div_ready) begin
                if (st_hold <= 1) bus.div_ready <= 1'b0;
                else st_hold <= st_hold - 1;
            end
        end
    end

    // Response monitor: records every accepted response
    always @(negedge clk) begin
        if (rstn && bus.rsp_valid && bus.rsp_ready)
            rsp_fifo.push_back({bus.rsp_timeout, bus.rsp_exc, bus.rsp_q, bus.rsp_r});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".cmd_ready"},    bus.cmd_ready,    64'd1);
        chk({tag, ".div_req"},      bus.div_req,      64'd0);
        chk({tag, ".div_dividend"}, bus.div_dividend, 64'd0);
        chk({tag, ".div_divisor"},  bus.div_divisor,  64'd0);
        chk({tag, ".rsp_valid"},    bus.rsp_valid,    64'd0);
        chk({tag, ".rsp_q"},        bus.rsp_q,        64'd0);
        chk({tag, ".rsp_r"},        bus.rsp_r,        64'd0);
        chk({tag, ".rsp_exc"},      bus.rsp_exc,      64'd0);
        chk({tag, ".rsp_timeout"},  bus.rsp_timeout,  64'd0);
        chk({tag, ".div_hung"},     bus.div_hung,     64'd0);
    endtask

    // Present one command until the FIFO takes it (ready sampled mid-cycle)
    task automatic push_one(input string name, input logic [15:0] dvd, input logic [15:0] dvs);
        bit done = 1'b0;
        int n = 0;
        @(negedge clk);
        while (!done && n < 2000) begin
            bus.cmd_valid    = 1'b1;
            bus.cmd_dividend = dvd;
            bus.cmd_divisor  = dvs;
            done = bus.cmd_ready;
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (!done) bound_fail({name, ".push"});
    endtask

    task automatic get_rsp(input string name, output logic [33:0] e);
        int n = 0;
        while (rsp_fifo.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (rsp_fifo.size() == 0) begin
            bound_fail({name, ".rsp"});
            e = 34'bx;
        end else begin
            e = rsp_fifo.pop_front();
        end
    endtask

    initial begin
        logic [33:0] e;
        int p0, idx, n, bad, t0;
        bit rdy, saw_full;

        tbl[0] = '{16'd100,   16'd7,   16'd14,    16'd2,     1'b0};
        tbl[1] = '{16'd55,    16'd0,   16'hFFFF,  16'd55,    1'b1};
        tbl[2] = '{16'd200,   16'd9,   16'd22,    16'd2,     1'b0};
        tbl[3] = '{16'd81,    16'd9,   16'd9,     16'd0,     1'b0};
        tbl[4] = '{16'd65535, 16'd1,   16'd65535, 16'd0,     1'b0};
        tbl[5] = '{16'd5,     16'd10,  16'd0,     16'd5,     1'b0};
        tbl[6] = '{16'd1000,  16'd33,  16'd30,    16'd10,    1'b0};
        tbl[7] = '{16'd0,     16'd5,   16'd0,     16'd0,     1'b0};
        tbl[8] = '{16'd65535, 16'd256, 16'd255,   16'd255,   1'b0};

        six[0] = '{16'd17,    16'd4,   16'd4,     16'd1,     1'b0};
        six[1] = '{16'd99,    16'd10,  16'd9,     16'd9,     1'b0};
        six[2] = '{16'd7,     16'd7,   16'd1,     16'd0,     1'b0};
        six[3] = '{16'd60000, 16'd7,   16'd8571,  16'd3,     1'b0};
        six[4] = '{16'd12345, 16'd0,   16'hFFFF,  16'd12345, 1'b1};
        six[5] = '{16'd256,   16'd16,  16'd16,    16'd0,     1'b0};

        rstn             = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_dividend = 16'd0;
        bus.cmd_divisor  = 16'd0;
        bus.rsp_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;

        // Table of single divisions with a free-running consumer
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            p0 = req_pulses;
            push_one($sformatf("tbl%0d", i), tbl[i].dvd, tbl[i].dvs);
            get_rsp($sformatf("tbl%0d", i), e);
            chk($sformatf("tbl%0d.q", i),   e[31:16], {48'd0, tbl[i].q});
            chk($sformatf("tbl%0d.r", i),   e[15:0],  {48'd0, tbl[i].r});
            chk($sformatf("tbl%0d.exc", i), e[32],    {63'd0, tbl[i].exc});
            chk($sformatf("tbl%0d.to", i),  e[33],    64'd0);
            chk($sformatf("tbl%0d.reqs", i), req_pulses - p0, tbl[i].exc ? 64'd0 : 64'd1);
        end

        // Six back-to-back commands: FIFO must fill and stall the producer
        saw_full = 1'b0;
        idx = 0;
        n = 0;
        @(negedge clk);
        while (idx < 6 && n < 2000) begin
            bus.cmd_valid    = 1'b1;
            bus.cmd_dividend = six[idx].dvd;
            bus.cmd_divisor  = six[idx].dvs;
            rdy = bus.cmd_ready;
            if (!rdy) saw_full = 1'b1;
            @(negedge clk);
            n++;
            if (rdy) idx++;
        end
        bus.cmd_valid = 1'b0;
        if (idx < 6) bound_fail("six.push");
        chk("six.cmd_ready_low_seen", saw_full, 64'd1);
        for (int i = 0; i < 6; i++) begin
            get_rsp($sformatf("six%0d", i), e);
            chk($sformatf("six%0d.res", i), e, {30'd0, 1'b0, six[i].exc, six[i].q, six[i].r});
        end

        // Consumer stalls: response must hold and no new issue may start
        bus.rsp_ready = 1'b0;
        push_one("hold0", 16'd200, 16'd9);
        push_one("hold1", 16'd50,  16'd5);
        n = 0;
        while (!bus.rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) bound_fail("hold.valid");
        p0 = req_pulses;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!(bus.rsp_valid === 1'b1 && bus.rsp_q === 16'd22 && bus.rsp_r === 16'd2)) bad++;
        end
        chk("hold.stable_errs", bad, 64'd0);
        chk("hold.no_new_req", req_pulses - p0, 64'd0);
        bus.rsp_ready = 1'b1;
        get_rsp("hold0", e);
        chk("hold0.res", e, {2'b00, 16'd22, 16'd2});
        get_rsp("hold1", e);
        chk("hold1.res", e, {2'b00, 16'd10, 16'd0});
        chk("hold.req_after_accept", req_pulses - p0, 64'd1);

        // Reset while the divider is busy
        p0 = req_pulses;
        push_one("midrst", 16'd1000, 16'd7);
        n = 0;
        while (req_pulses == p0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (req_pulses == p0) bound_fail("midrst.req");
        repeat (5) @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset("midrst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        chk("midrst.no_stale_rsp", rsp_fifo.size(), 64'd0);
        push_one("post_rst", 16'd81, 16'd9);
        get_rsp("post_rst", e);
        chk("post_rst.res", e, {2'b00, 16'd9, 16'd0});

        // Divider never answers: watchdog fires and the block stops issuing
        div_dead = 1'b1;
        push_one("tmo", 16'd300, 16'd3);
        get_rsp("tmo", e);
        t0 = cyc - last_req_cyc;
        chk("tmo.res", e, {2'b10, 16'd0, 16'd0});
        chk("tmo.hung", bus.div_hung, 64'd1);
        chk("tmo.latency_in_range", (t0 >= 1024 && t0 <= 1040), 64'd1);
        p0 = req_pulses;
        for (int i = 0; i < 4; i++) push_one($sformatf("hung%0d", i), 16'd40 + 16'(i), 16'd3);
        repeat (3) @(negedge clk);
        chk("hung.cmd_ready_full", bus.cmd_ready, 64'd0);
        repeat (100) @(negedge clk);
        chk("hung.no_issue", req_pulses - p0, 64'd0);
        chk("hung.no_rsp", rsp_fifo.size(), 64'd0);
        chk("hung.sticky", bus.div_hung, 64'd1);

        chk("never_req_while_ready", req_while_ready, 64'd0);

        #2 rstn = 1'b0;
        #1 check_reset("final");
        @(negedge clk);
        rstn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
